// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings for the receive collector and the
// transmit driver, the line terminator and a small saturating helper.
package uart_pkg;

    localparam logic [7:0] ASCII_LF = 8'd10;

    typedef enum logic [1:0] {
        RX_INIT         = 2'd0,
        RX_IDLE         = 2'd1,
        RX_WAIT_RELEASE = 2'd2,
        RX_LINE_DONE    = 2'd3
    } rx_state_t;

    // Transmit driver handshake states, kept beside the receive states so both
    // directions of the UART share one encoding source.
    typedef enum logic [1:0] {
        TX_INIT         = 2'd0,
        TX_IDLE         = 2'd1,
        TX_WAIT_ACK     = 2'd2,
        TX_WAIT_RELEASE = 2'd3
    } tx_state_t;

    // 8-bit increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Line buffer storage: DEPTH x 8, synchronous write, registered read.
// Kept separate so it can be mapped onto a block RAM; only the read register
// is reset, the array itself keeps its contents across reset.
module line_buffer_ram #(
    parameter int DEPTH  = 13,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // Write port: one byte per accepted character.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read port: addresses past the array hold the previous output.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= 8'd0;
        else if (int'(raddr) < DEPTH)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/rx_line_collector.sv
// Receive line collector: takes bytes from the UART receiver through a
// full/acknowledge handshake, assembles them into a line buffer, and exposes
// the finished line until the consumer releases it.
module rx_line_collector
    import uart_pkg::*;
#(
    parameter int LINE_MAX = 13,
    parameter int ADDR_W   = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RxFull,
    input  logic [7:0]        RxData,
    input  logic              RxErr,
    output logic              RxAck,
    output logic              LineReady,
    output logic [ADDR_W:0]   LineLen,
    output logic              Overflow,
    input  logic              LineTaken,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [7:0]        RdData,
    output logic [7:0]        ErrCount
);

    rx_state_t         state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              line_close;   // byte in flight ends the line
    logic              line_ovf;     // ...and it ended by filling the buffer

    logic accept, accept_good, release_byte, take, last_slot, is_lf;

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset)
            state <= RX_INIT;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = RX_INIT;
        case (state)
            RX_INIT:         state_nxt = RX_IDLE;
            RX_IDLE:         state_nxt = RxFull ? RX_WAIT_RELEASE : RX_IDLE;
            RX_WAIT_RELEASE: state_nxt = RxFull     ? RX_WAIT_RELEASE :
                                         line_close ? RX_LINE_DONE : RX_IDLE;
            RX_LINE_DONE:    state_nxt = LineTaken ? RX_IDLE : RX_LINE_DONE;
            default:         state_nxt = RX_INIT;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        accept       = (state == RX_IDLE) && RxFull;
        accept_good  = accept && !RxErr;
        release_byte = (state == RX_WAIT_RELEASE) && !RxFull;
        take         = (state == RX_LINE_DONE) && LineTaken;
        last_slot    = (wr_ptr == ADDR_W'(LINE_MAX - 1));
        is_lf        = (RxData == ASCII_LF);
    end

    // Handshake, write pointer, line flags and error counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            RxAck      <= 1'b0;
            LineReady  <= 1'b0;
            LineLen    <= '0;
            Overflow   <= 1'b0;
            ErrCount   <= 8'd0;
            wr_ptr     <= '0;
            line_close <= 1'b0;
            line_ovf   <= 1'b0;
        end else begin
            if (state == RX_INIT) begin
                wr_ptr    <= '0;
                LineReady <= 1'b0;
                Overflow  <= 1'b0;
                RxAck     <= 1'b0;
            end
            if (accept) begin
                RxAck <= 1'b1;
                if (RxErr) begin
                    // Errored byte is dropped and never closes the line.
                    ErrCount   <= sat_inc8(ErrCount);
                    line_close <= 1'b0;
                    line_ovf   <= 1'b0;
                end else begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    line_close <= is_lf || last_slot;
                    line_ovf   <= last_slot && !is_lf;
                end
            end
            if (release_byte) begin
                RxAck <= 1'b0;
                if (line_close) begin
                    LineLen   <= {1'b0, wr_ptr};
                    LineReady <= 1'b1;
                    Overflow  <= line_ovf;
                end
            end
            if (take) begin
                LineReady <= 1'b0;
                Overflow  <= 1'b0;
                wr_ptr    <= '0;
            end
        end
    end

    line_buffer_ram #(
        .DEPTH  (LINE_MAX),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (Clock),
        .rst   (Reset),
        .we    (accept_good),
        .waddr (wr_ptr),
        .wdata (RxData),
        .raddr (RdAddr),
        .rdata (RdData)
    );

endmodule

// File: tb/tb_rx_line_collector.sv
// Bench for rx_line_collector: a driver feeds bytes through the handshake and
// updates a line-level model; a monitor consumes each finished line and
// compares it against the model's queue of expected lines.
module tb_rx_line_collector;
    import uart_pkg::*;

    localparam int LINE_MAX = 13;
    localparam int ADDR_W   = 4;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              RxFull = 1'b0;
    logic [7:0]        RxData = 8'd0;
    logic              RxErr = 1'b0;
    logic              RxAck;
    logic              LineReady;
    logic [ADDR_W:0]   LineLen;
    logic              Overflow;
    logic              LineTaken;
    logic [ADDR_W-1:0] RdAddr = '0;
    logic [7:0]        RdData;
    logic [7:0]        ErrCount;

    logic take_main = 1'b0;
    logic take_mon  = 1'b0;
    assign LineTaken = take_main | take_mon;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    rx_line_collector #(.LINE_MAX(LINE_MAX), .ADDR_W(ADDR_W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .RxFull    (RxFull),
        .RxData    (RxData),
        .RxErr     (RxErr),
        .RxAck     (RxAck),
        .LineReady (LineReady),
        .LineLen   (LineLen),
        .Overflow  (Overflow),
        .LineTaken (LineTaken),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .ErrCount  (ErrCount)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int         len;
        bit         ovf;
        logic [7:0] data [LINE_MAX];
    } line_t;

    line_t      exp_q[$];
    logic [7:0] cur_line[$];
    int         model_err = 0;

    function automatic void model_byte(input logic [7:0] d, input logic e);
        line_t l;
        if (e) begin
            if (model_err < 255) model_err++;
            return;
        end
        cur_line.push_back(d);
        if (d == 8'd10 || cur_line.size() == LINE_MAX) begin
            l.len = cur_line.size();
            l.ovf = (d != 8'd10);
            for (int i = 0; i < LINE_MAX; i++)
                l.data[i] = (i < l.len) ? cur_line[i] : 8'd0;
            exp_q.push_back(l);
            cur_line.delete();
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at a negedge after the handshake closes.
    task automatic send_byte(input logic [7:0] d, input logic e, input int gap);
        int n;
        RxData = d;
        RxErr  = e;
        RxFull = 1'b1;
        n = 0;
        do begin @(negedge Clock); n++; end while (!RxAck && n < 600);
        if (!RxAck) begin
            chk("ack_timeout", 0, 1);
            RxFull = 1'b0;
            return;
        end
        RxFull = 1'b0;
        model_byte(d, e);
        n = 0;
        do begin @(negedge Clock); n++; end while (RxAck && n < 10);
        chk("ack_drop_latency", n, 1);
        repeat (gap) @(negedge Clock);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || LineReady) && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        if (exp_q.size() != 0 || LineReady) chk("drain_timeout", 0, 1);
        repeat (3) @(negedge Clock);
    endtask

    // ---------------- monitor / consumer ----------------
    initial begin : monitor
        line_t l;
        bit    pend;
        forever begin
            @(negedge Clock);
            if (LineReady && !Reset) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_line", 0, 1);
                    l.len = 0;
                    l.ovf = 1'b0;
                end else begin
                    l = exp_q.pop_front();
                    chk("line_len", LineLen, l.len);
                    chk("overflow", Overflow, l.ovf);
                end
                for (int a = 0; a < l.len; a++) begin
                    RdAddr = ADDR_W'(a);
                    @(negedge Clock);
                    chk("rd_data", RdData, l.data[a]);
                    chk("ack_backpressure", RxAck, 0);
                end
                repeat ($urandom_range(0, 3)) @(negedge Clock);
                take_mon = 1'b1;
                @(posedge Clock);
                pend = RxFull;
                @(negedge Clock);
                take_mon = 1'b0;
                chk("line_release", LineReady, 0);
                chk("ack_at_release", RxAck, 0);
                if (pend) begin
                    @(negedge Clock);
                    chk("ack_after_release", RxAck, 1);
                end
            end
        end
    end

    // Hard bound on the whole run.
    initial begin : watchdog
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0] hello [13] = '{72, 101, 108, 108, 111, 32, 87, 111, 114, 108, 100, 33, 10};

    initial begin : stim
        int cnt;
        @(negedge Clock);
        chk("rst_ack", RxAck, 0);
        chk("rst_ready", LineReady, 0);
        chk("rst_len", LineLen, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_errcnt", ErrCount, 0);
        chk("rst_rddata", RdData, 0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // Full line terminated by LF, slow sender.
        for (int i = 0; i < 13; i++) send_byte(hello[i], 1'b0, 6);
        wait_drain();

        // Buffer-full close; byte 14 is held off until release.
        for (int i = 0; i < 14; i++) send_byte(8'h41, 1'b0, 1);
        send_byte(8'd10, 1'b0, 0);
        wait_drain();

        // Error byte mid-line, then counter saturation.
        for (int i = 0; i < 3; i++) send_byte(8'h78, 1'b0, 0);
        send_byte(8'h55, 1'b1, 0);
        chk("errcnt_one", ErrCount, model_err);
        for (int i = 0; i < 256; i++) send_byte(8'($urandom), 1'b1, 0);
        chk("errcnt_sat", ErrCount, 8'hFF);
        send_byte(8'd10, 1'b0, 0);
        wait_drain();

        // Error byte on the last slot neither writes nor closes.
        for (int i = 0; i < 12; i++) send_byte(8'(8'h30 + i), 1'b0, 0);
        send_byte(8'h5A, 1'b1, 2);
        chk("err_last_no_close", LineReady, 0);
        send_byte(8'h7A, 1'b0, 0);
        wait_drain();

        // RxFull held for 20 cycles: one byte, ack for 20 cycles.
        RxData = 8'h99;
        RxErr  = 1'b0;
        RxFull = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge Clock);
            if (RxAck) cnt++;
        end
        RxFull = 1'b0;
        model_byte(8'h99, 1'b0);
        @(negedge Clock);
        chk("held_ack_drop", RxAck, 0);
        chk("held_ack_cycles", cnt, 20);
        send_byte(8'd10, 1'b0, 0);
        wait_drain();

        // Reset in the middle of a line.
        for (int i = 0; i < 5; i++) send_byte(8'(8'h61 + i), 1'b0, 0);
        RdAddr = 4'd1;
        Reset  = 1'b1;
        @(negedge Clock);
        chk("mid_rst_ack", RxAck, 0);
        chk("mid_rst_ready", LineReady, 0);
        chk("mid_rst_len", LineLen, 0);
        chk("mid_rst_ovf", Overflow, 0);
        chk("mid_rst_errcnt", ErrCount, 0);
        chk("mid_rst_rddata", RdData, 0);
        cur_line.delete();
        model_err = 0;
        Reset = 1'b0;
        @(negedge Clock);

        // "AB" + LF, with a stray LineTaken in idle that must be ignored.
        send_byte(8'h41, 1'b0, 0);
        send_byte(8'h42, 1'b0, 1);
        take_main = 1'b1;
        @(negedge Clock);
        take_main = 1'b0;
        @(negedge Clock);
        chk("idle_take_ignored", LineReady, 0);
        send_byte(8'd10, 1'b0, 0);
        wait_drain();

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            logic [7:0] d;
            logic       e;
            e = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 7) == 0) ? 8'd10 : 8'($urandom);
            send_byte(d, e, $urandom_range(0, 3));
        end
        if (cur_line.size() != 0) send_byte(8'd10, 1'b0, 0);
        wait_drain();
        chk("rand_errcnt", ErrCount, model_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_line_collector.md
# rx_line_collector

Receive-side counterpart of the transmit driver: sits behind the UART receiver, takes each received byte through a full/acknowledge handshake, and assembles bytes into a line buffer. A line closes on ASCII LF (8'd10) or when the buffer fills. A completed line is exposed through a registered read port until the consumer releases it. Framing-errored bytes are acknowledged, discarded and counted.

## Interface
- LINE_MAX, 13: buffer depth in bytes; also the maximum line length.
- ADDR_W, 4: width of the write pointer and RdAddr; must satisfy 2**ADDR_W >= LINE_MAX.

- Clock  input  1  single clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high.
- RxFull  input  1  receiver holds a valid byte; stays high until RxAck is seen.
- RxData  input  8  received byte; valid while RxFull=1.
- RxErr  input  1  framing error on the current byte; valid while RxFull=1.
- RxAck  output  1  byte taken; held high until RxFull drops.
- LineReady  output  1  a complete line is in the buffer.
- LineLen  output  ADDR_W+1  bytes in the completed line, including LF.
- Overflow  output  1  line closed by buffer-full, not by LF.
- LineTaken  input  1  one-cycle pulse from the consumer that releases the line.
- RdAddr  input  ADDR_W  read address.
- RdData  output  8  buffer byte at RdAddr, registered.
- ErrCount  output  8  saturating count of discarded framing-error bytes.

## Operation
- States: RX_INIT, RX_IDLE, RX_WAIT_RELEASE, RX_LINE_DONE. Undefined encodings go to RX_INIT.
- RX_INIT:
  - WrPtr<=0, LineReady<=0, Overflow<=0, RxAck<=0.
  - Next state RX_IDLE.
- RX_IDLE, when RxFull=1:
  - If RxErr=1: byte not written. ErrCount increments, saturating at 8'hFF. RxAck<=1. Close flag <=0.
  - If RxErr=0: mem[WrPtr]<=RxData, WrPtr<=WrPtr+1, RxAck<=1.
  - Close flag <=1 if RxData==LF or WrPtr==LINE_MAX-1.
  - Overflow flag <=1 only when the buffer filled and RxData!=LF.
  - Next state RX_WAIT_RELEASE.
- RX_IDLE, when RxFull=0: stay.
- RX_WAIT_RELEASE:
  - Hold RxAck=1 while RxFull=1.
  - On RxFull sampled 0: RxAck<=0.
  - If close flag set: LineLen<=WrPtr, LineReady<=1, Overflow<=overflow flag, next state RX_LINE_DONE.
  - Otherwise next state RX_IDLE.
- RX_LINE_DONE:
  - RxAck stays 0 and no byte is accepted. This is back-pressure on the receiver.
  - On LineTaken=1: LineReady<=0, Overflow<=0, WrPtr<=0, next state RX_IDLE.
  - LineTaken in any other state is ignored.
- Read port:
  - RdData<=mem[RdAddr] on every clock, in every state.
  - RdAddr >= LineLen returns stale buffer contents; this is not an error.
- Reset, including mid-line:
  - Next state RX_INIT. The partial line is dropped.
  - RxAck=0, LineReady=0, LineLen=0, Overflow=0, ErrCount=0, RdData=0.
  - Buffer contents are not cleared.

## Timing
- Byte accepted at edge k (RX_IDLE with RxFull=1). RxAck is high from cycle k+1.
- RxFull sampled low at edge m. RxAck is low from cycle m+1.
- LineReady rises one cycle after the release edge of the closing byte.
- Read latency: one cycle from RdAddr to RdData.
- Minimum spacing between bytes: 2 cycles (IDLE → WAIT_RELEASE → IDLE).
- LineTaken sampled at edge t: LineReady low from cycle t+1. The next byte can be accepted at edge t+1.
- RxFull and LineTaken both high in RX_LINE_DONE: the line is released this edge and the byte is accepted on the following edge. No byte is lost.
- Error byte on the last buffer slot: not written and does not close the line.

## Structure
- Shared package uart_pkg:
  - rx_state_t enum for the four states.
  - ASCII_LF = 8'd10.
  - The transmit driver's state constants move into the same package.
- Sub-module line_buffer_ram: LINE_MAX x 8, synchronous write, registered read. Separated out so it can be mapped onto a block RAM.
- Top level holds the FSM, WrPtr, flags and ErrCount.

## Test plan
- Send "Hello World!" + LF (13 bytes, 72..33, 10), 6 idle cycles between bytes, RxFull held until RxAck → LineReady=1, LineLen=13, Overflow=0, RdAddr 0..12 returns the same bytes one cycle later.
- 14 non-LF bytes (8'h41) → after byte 13: LineReady=1, LineLen=13, Overflow=1. Byte 14 gets RxAck=0 until LineTaken. After LineTaken it is stored at address 0.
- Byte 8'h55 with RxErr=1 mid-line → RxAck handshake completes, WrPtr unchanged, ErrCount=1. Then 256 error bytes → ErrCount stays 8'hFF.
- RxFull held high for 20 cycles → RxAck high for 20 cycles, exactly one byte stored. RxAck drops the cycle after RxFull falls.
- Reset after 5 bytes of a line → all outputs return to reset values next cycle. The next line "AB"+LF gives LineLen=3 starting at address 0.
- LineTaken pulsed in RX_IDLE → no effect. LineTaken and RxFull asserted together in RX_LINE_DONE → release, then the byte is accepted one cycle later at address 0.
